pin_uart_tx: RTL and testbench
==============================

Name: pin_uart_tx

Overview:
- Serial transmitter that sits inside the tt_um_XD user design and drives one dedicated output pin (uo_out[0]) with 8N1 UART frames.
- It is the sending end of the serial link whose receiving end is the cocotb host bench sampling uo_out.
- Bytes are pushed in through a valid/ready interface and buffered in a small FIFO.
- Frames are serialised LSB first at a fixed clocks-per-bit rate.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, byte entries in the input FIFO; power of two, 2..16.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_data  input  8  byte to enqueue.
- wr_valid  input  1  wr_data is valid this cycle.
- wr_ready  output  1  FIFO can accept a byte; equals (fifo_count < FIFO_DEPTH), driven from registers only.
- tx  output  1  serial line; idle high.
- busy  output  1  high whenever the state is not IDLE or fifo_count != 0.
- fifo_count  output  clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.

Behaviour:
- Reset (async assert, sync-clean deassert by clk): tx=1, busy=0, fifo_count=0, wr_ready=1, state=IDLE, FIFO pointers and bit/baud counters cleared.
- Reset asserted mid-frame forces tx high immediately and discards the queued bytes and the frame in progress.
- Write: a byte is accepted on a rising edge where wr_valid && wr_ready. fifo_count increments after that edge.
- Write when full: wr_ready=0, so the byte is dropped silently. There is no state change and no error flag.
- Write while wr_ready=0 because full and a pop occurs on the same edge: the write is still not accepted, since wr_ready is registered-state based.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If fifo_count != 0 on an edge: pop the head byte into the shift register, zero the baud counter, bit index=0, go to START. fifo_count decrements.
  - A simultaneous write and pop on that edge leaves fifo_count unchanged.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit.
  - After bit index 7 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: a byte accepted at edge N into an empty FIFO while IDLE is popped at edge N+1. tx falls after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames are separated by exactly one clock of idle-high: the IDLE pop cycle.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Its width is clog2(CLKS_PER_BIT).
- FIFO pointers are clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are distinguished by fifo_count, not by pointer equality.
- busy drops to 0 on the edge STOP→IDLE only when fifo_count==0.
- tx is a registered output with no combinational path from inputs.

Test Plan:
- Reset then idle 100 cycles -> tx=1, busy=0, wr_ready=1, fifo_count=0 throughout.
- Write 0xA5 with CLKS_PER_BIT=16 -> tx falls one cycle after acceptance. Sampling at bit centres gives 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). busy is high for 161 cycles.
- Write 0x00,0xFF,0x3C,0x81 on consecutive cycles -> all accepted, fifo_count peaks at 3. Four frames decode in order, each separated by exactly one idle-high cycle.
- Fill the FIFO with 4 bytes while the first frame is active (5 writes total) -> wr_ready=0 when fifo_count=4. A 6th write of 0x77 is dropped; the decoded stream contains exactly the first 5 bytes.
- Assert rst during the DATA bit 3 of 0x55 with 2 bytes queued -> tx=1 within the same cycle, fifo_count=0. After release no further frames appear.
- CLKS_PER_BIT=2, write 0x80 -> frame is exactly 20 cycles with tx low for cycles 0..15 and high for 16..19, verifying the minimum rate.

Source files
------------

// File: rtl/pin_uart_tx.sv
// pin_uart_tx: 8N1 UART transmitter driving a single output pin.
// Bytes enter through a valid/ready port into a small FIFO and are
// serialised LSB first at CLKS_PER_BIT clocks per bit.
//
// Handshake: a byte is taken on a rising edge where wr_valid && wr_ready.
// wr_ready depends only on registered state (fifo_count < FIFO_DEPTH), so a
// pop on the same edge never turns a write seen as "full" into an accepted one.
module pin_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q;
  logic [7:0]      shift_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic            tx_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  logic            push;
  logic            pop;
  logic            baud_last;

  assign wr_ready   = (count_q < DEPTH_C);
  assign push       = wr_valid && wr_ready;
  assign pop        = (state_q == IDLE) && (count_q != '0);
  assign baud_last  = (baud_q == BAUD_LAST);
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count; pointers wrap naturally, count tells full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit; tx registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pin_uart_tx.sv
// tb_pin_uart_tx: directed bench for pin_uart_tx at 16 and 2 clocks per bit.
module tb_pin_uart_tx;

  logic       clk;
  logic       rst;

  // Instance A: CLKS_PER_BIT = 16
  logic [7:0] wr_data_a;
  logic       wr_valid_a;
  logic       wr_ready_a;
  logic       tx_a;
  logic       busy_a;
  logic [2:0] fifo_count_a;

  // Instance B: CLKS_PER_BIT = 2
  logic [7:0] wr_data_b;
  logic       wr_valid_b;
  logic       wr_ready_b;
  logic       tx_b;
  logic       busy_b;
  logic [2:0] fifo_count_b;

  int passed = 0;
  int total  = 0;

  pin_uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .wr_data(wr_data_a), .wr_valid(wr_valid_a),
    .wr_ready(wr_ready_a), .tx(tx_a), .busy(busy_a), .fifo_count(fifo_count_a)
  );

  pin_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .wr_data(wr_data_b), .wr_valid(wr_valid_b),
    .wr_ready(wr_ready_b), .tx(tx_b), .busy(busy_b), .fifo_count(fifo_count_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line decoder for instance A, sampling at negedges (mid-cycle).
  logic [7:0] rx_q[$];
  logic [9:0] frame_bits_q[$];
  int         gap_q[$];
  logic       mon_in_frame = 1'b0;
  int         mon_phase = 0;
  int         mon_idle = 0;
  logic [9:0] mon_bits;

  always @(negedge clk) begin
    if (rst) begin
      mon_in_frame = 1'b0;
      mon_idle     = 0;
    end else begin
      if (!mon_in_frame && tx_a == 1'b0) begin
        mon_in_frame = 1'b1;
        mon_phase    = 0;
        mon_bits     = '0;
        gap_q.push_back(mon_idle);
        mon_idle     = 0;
      end else if (!mon_in_frame) begin
        mon_idle++;
      end
      if (mon_in_frame) begin
        if (mon_phase % 16 == 8) mon_bits[mon_phase / 16] = tx_a;
        if (mon_phase == 159) begin
          mon_in_frame = 1'b0;
          rx_q.push_back(mon_bits[8:1]);
          frame_bits_q.push_back(mon_bits);
        end else begin
          mon_phase++;
        end
      end
    end
  end

  // Driver: called at a negedge, holds one write for one clock edge.
  task automatic write_a(input logic [7:0] d);
    wr_data_a  = d;
    wr_valid_a = 1'b1;
    @(negedge clk);
    wr_valid_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget, output int used);
    used = 0;
    while (busy_a && used < budget) begin
      used++;
      @(negedge clk);
    end
  endtask

  task automatic clear_monitor();
    rx_q.delete();
    frame_bits_q.delete();
    gap_q.delete();
  endtask

  task automatic test_reset();
    logic [5:0] exp_v;
    logic [5:0] act_v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_a, busy_a, wr_ready_a, fifo_count_a} !== 6'b101000) begin
      $display("FAIL reset_hold: tx/busy/ready/count=%b required 101000",
               {tx_a, busy_a, wr_ready_a, fifo_count_a});
    end else passed++;
    rst = 1'b0;
    exp_v = 6'b101000;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      act_v = {tx_a, busy_a, wr_ready_a, fifo_count_a};
      total++;
      if (act_v !== exp_v) begin
        $display("FAIL reset_idle cycle %0d: tx/busy/ready/count=%b required %b", i, act_v, exp_v);
      end else passed++;
    end
  endtask

  task automatic test_single_frame();
    int cnt;
    logic [9:0] exp_bits;
    logic [9:0] got_bits;
    clear_monitor();
    write_a(8'hA5);
    total++;
    if ({tx_a, busy_a, fifo_count_a} !== 5'b11001) begin
      $display("FAIL single_accept: tx/busy/count=%b required 11001", {tx_a, busy_a, fifo_count_a});
    end else passed++;
    cnt = 0;
    while (busy_a && cnt < 400) begin
      if (cnt == 1) begin
        total++;
        if (tx_a !== 1'b0) $display("FAIL single_start_latency: tx=%b required 0", tx_a);
        else passed++;
      end
      cnt++;
      @(negedge clk);
    end
    total++;
    if (cnt != 161) $display("FAIL single_busy_len: got %0d cycles required 161", cnt);
    else passed++;
    total++;
    if (frame_bits_q.size() != 1) begin
      $display("FAIL single_frame_count: got %0d frames required 1", frame_bits_q.size());
    end else begin
      passed++;
      exp_bits = 10'h34A;
      got_bits = frame_bits_q[0];
      for (int k = 0; k < 10; k++) begin
        total++;
        if (got_bits[k] !== exp_bits[k]) begin
          $display("FAIL single_bit%0d: got %b required %b", k, got_bits[k], exp_bits[k]);
        end else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] vec[4];
    logic [2:0] peak;
    int used;
    clear_monitor();
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h3C; vec[3] = 8'h81;
    peak = '0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vec[i]);
      wr_data_a  = vec[i];
      wr_valid_a = 1'b1;
      total++;
      if (wr_ready_a !== 1'b1) $display("FAIL b2b_ready%0d: got %b required 1", i, wr_ready_a);
      else passed++;
      @(negedge clk);
      if (fifo_count_a > peak) peak = fifo_count_a;
    end
    wr_valid_a = 1'b0;
    used = 0;
    while (busy_a && used < 1000) begin
      if (fifo_count_a > peak) peak = fifo_count_a;
      used++;
      @(negedge clk);
    end
    total++;
    if (busy_a) $display("FAIL b2b_timeout: busy=%b required 0 within 1000 cycles", busy_a);
    else passed++;
    total++;
    if (peak !== 3'd3) $display("FAIL b2b_peak: got %0d required 3", peak);
    else passed++;
    total++;
    if (rx_q.size() != 4) $display("FAIL b2b_frames: got %0d required 4", rx_q.size());
    else passed++;
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      logic [7:0] e;
      logic [7:0] g;
      e = exp_q.pop_front();
      g = rx_q.pop_front();
      total++;
      if (g !== e) $display("FAIL b2b_data: got %h required %h", g, e);
      else passed++;
    end
    for (int i = 1; i < gap_q.size(); i++) begin
      total++;
      if (gap_q[i] != 1) $display("FAIL b2b_gap%0d: got %0d idle cycles required 1", i, gap_q[i]);
      else passed++;
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp_q[$];
    logic [7:0] vec[5];
    int used;
    clear_monitor();
    vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33; vec[3] = 8'h44; vec[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vec[i]);
      write_a(vec[i]);
    end
    total++;
    if ({wr_ready_a, fifo_count_a} !== 4'b0100) begin
      $display("FAIL fill_full: ready/count=%b required 0100", {wr_ready_a, fifo_count_a});
    end else passed++;
    write_a(8'h77);
    total++;
    if (fifo_count_a !== 3'd4) $display("FAIL fill_drop: count=%0d required 4", fifo_count_a);
    else passed++;
    wait_idle_a(2000, used);
    total++;
    if (busy_a) $display("FAIL fill_timeout: busy=%b required 0 within 2000 cycles", busy_a);
    else passed++;
    total++;
    if (rx_q.size() != 5) $display("FAIL fill_frames: got %0d required 5", rx_q.size());
    else passed++;
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      logic [7:0] e;
      logic [7:0] g;
      e = exp_q.pop_front();
      g = rx_q.pop_front();
      total++;
      if (g !== e) $display("FAIL fill_data: got %h required %h", g, e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    clear_monitor();
    write_a(8'h55);
    write_a(8'h12);
    write_a(8'h34);
    // Now at frame cycle 1; advance to cycle 71, inside data bit 3.
    repeat (70) @(negedge clk);
    total++;
    if ({tx_a, fifo_count_a} !== 4'b0010) begin
      $display("FAIL mid_before: tx/count=%b required 0010", {tx_a, fifo_count_a});
    end else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({tx_a, busy_a, wr_ready_a, fifo_count_a} !== 6'b101000) begin
      $display("FAIL mid_reset: tx/busy/ready/count=%b required 101000",
               {tx_a, busy_a, wr_ready_a, fifo_count_a});
    end else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) lows++;
    end
    total++;
    if (lows != 0) $display("FAIL mid_quiet: got %0d active cycles required 0", lows);
    else passed++;
    total++;
    if (rx_q.size() != 0) $display("FAIL mid_frames: got %0d frames required 0", rx_q.size());
    else passed++;
  endtask

  task automatic test_min_rate();
    logic exp_tx;
    wr_data_b  = 8'h80;
    wr_valid_b = 1'b1;
    @(negedge clk);
    wr_valid_b = 1'b0;
    total++;
    if ({tx_b, busy_b, fifo_count_b} !== 5'b11001) begin
      $display("FAIL min_accept: tx/busy/count=%b required 11001", {tx_b, busy_b, fifo_count_b});
    end else passed++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp_tx = (c >= 16);
      total++;
      if ({tx_b, busy_b} !== {exp_tx, 1'b1}) begin
        $display("FAIL min_cycle%0d: tx/busy=%b required %b", c, {tx_b, busy_b}, {exp_tx, 1'b1});
      end else passed++;
    end
    @(negedge clk);
    total++;
    if ({tx_b, busy_b} !== 2'b10) $display("FAIL min_end: tx/busy=%b required 10", {tx_b, busy_b});
    else passed++;
  endtask

  initial begin
    rst        = 1'b1;
    wr_data_a  = '0;
    wr_valid_a = 1'b0;
    wr_data_b  = '0;
    wr_valid_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    repeat (5) @(negedge clk);
    test_back_to_back();
    repeat (5) @(negedge clk);
    test_fill();
    repeat (5) @(negedge clk);
    test_reset_mid_frame();
    test_min_rate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
